sram_1p_bwe_init: RTL and testbench
===================================

# sram_1p_bwe_init

Parametrised single-port synchronous SRAM behavioural model with active-low chip enable, active-low write enable, and per-lane active-low byte write enables. It extends the fixed-size single-port macro models used under cache data and tag arrays in three ways: a self-clearing initialisation sequencer after reset, output hold when not reading, and defined behaviour for out-of-range addresses. It sits in the same place in the design as those macro models, underneath the cache and TLB array wrappers.

## Interface
Parameters:
- Bits, 64, data word width; must be a multiple of Gran.
- Word_Depth, 128, number of words.
- Add_Width, 7, address width; Word_Depth ≤ 2^Add_Width.
- Gran, 8, bits per write lane; Lanes = Bits/Gran.

Ports:
- CLK  input  1  single clock; all activity on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- CEB  input  1  chip enable, active low.
- WEB  input  1  write enable, active low (0 = write, 1 = read).
- BWEB  input  Lanes  per-lane write enable, active low; bit i covers D[i*Gran +: Gran].
- A  input  Add_Width  word address.
- D  input  Bits  write data.
- Q  output  Bits  read data, registered.
- INIT_DONE  output  1  high once the array is cleared and accesses are accepted.

## Operation
- The FSM has two states, INIT and READY, with a clear counter cnt of width Add_Width.
- RST high (any state): next state INIT, cnt=0, Q=0, INIT_DONE=0; no array write occurs on that edge.
- INIT: each edge with RST low writes all-zero to ram[cnt] and increments cnt. On the edge where cnt==Word_Depth-1, that write completes and the state moves to READY. CEB/WEB/BWEB/A/D are ignored and Q holds 0.
- READY, CEB=0, WEB=0: for each lane i with BWEB[i]=0, write ram[A] lane i with D lane i. Lanes with BWEB[i]=1 are unchanged. Q holds its previous value.
- READY, CEB=0, WEB=1: Q ← ram[A] on the same edge.
- READY, CEB=1: no access; Q holds its previous value. There is no random value on Q.
- Out-of-range address (A ≥ Word_Depth): the write is dropped and a read loads Q=0.
- RST asserted mid-INIT: the sequence restarts from cnt=0. Array contents are undefined until a full clear completes.
- INIT_DONE = (state==READY), driven from a register.

## Timing
- Reset values: Q=0, INIT_DONE=0.
- With RST low starting at edge 1, the clearing writes occur at edges 1..Word_Depth. INIT_DONE is high after edge Word_Depth, and the first user access is sampled at edge Word_Depth+1.
- Read latency is 1 cycle: the address is sampled at edge N and Q is valid after edge N.
- A read at edge N+1 of an address written at edge N returns the new data.
- The single port means there is no simultaneous read and write. WEB=0 always means write and never returns data.
- An all-ones BWEB write with CEB=0 is a legal no-op and does not change Q.

## Structure
- Shared package sram_pkg: state enum (INIT, READY) and a lane-count helper function Bits/Gran. Widths stay module parameters.
- One sub-module is natural: sram_bwe_array, holding the storage with the lane-masked write port and the registered read. The top module holds the FSM, counter, and the mux that selects between clear and user access.

## Test plan
- Reset then init, with Word_Depth=128: release RST. INIT_DONE rises after exactly 128 edges, and reads of addresses 0, 64, and 127 return 0.
- Byte-lane write: write A=5, D=0x1122334455667788, BWEB=0x00. Then write A=5, D=0xFFFF…FF, BWEB=0xF0. Reading A=5 returns 0x11223344FFFFFFFF.
- Q hold: read A=5, then 3 cycles with CEB=1, then a write to A=6. Q stays at the A=5 data throughout.
- Read-after-write: write A=9 with D=0xA5A5… at edge N, read A=9 at edge N+1. Q=0xA5A5… after edge N+1.
- Access during INIT plus mid-init reset: drive write traffic while cnt=40, then assert RST for one cycle. INIT_DONE stays 0 and re-rises 128 edges after release, and all addresses read 0.
- Out-of-range, with Word_Depth=100 and Add_Width=7: a write to A=120 is dropped, a read of A=120 gives Q=0, and ram[120-100] is unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the single-port SRAM model with an initialisation clear.
//   state_e : sequencer states (INIT clears the array, READY accepts accesses)
//   lanes() : number of byte-enable lanes for a given word width and lane size
package sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int lanes(input int bits, input int gran);
    return bits / gran;
  endfunction

endpackage

// File: rtl/sram_bwe_array.sv
// Storage for the SRAM model: lane-masked write port and registered read.
//   clk, rst : clock, synchronous active-high reset (clears only the read register)
//   we       : write strobe, wmask selects lanes (active high)
//   re       : read strobe, q loads the addressed word on the same edge
//   addr     : word address, wdata : write data, q : registered read data
// Addresses at or beyond Word_Depth drop writes and read back as zero.
module sram_bwe_array
  import sram_pkg::*;
#(
  parameter int Bits       = 64,
  parameter int Word_Depth = 128,
  parameter int Add_Width  = 7,
  parameter int Gran       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         re,
  input  logic [lanes(Bits,Gran)-1:0]  wmask,
  input  logic [Add_Width-1:0]         addr,
  input  logic [Bits-1:0]              wdata,
  output logic [Bits-1:0]              q
);

  localparam int Lanes = lanes(Bits, Gran);

  logic [Bits-1:0] mem_q [Word_Depth];
  logic [Bits-1:0] q_q, q_d;
  logic            in_range;

  assign in_range = (32'(addr) < Word_Depth);

  // Q only moves on a read; otherwise it holds whatever was last loaded.
  always_comb begin
    q_d = q_q;
    if (re) q_d = in_range ? mem_q[addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int i = 0; i < Lanes; i++) begin
        if (wmask[i]) mem_q[addr][i*Gran +: Gran] <= wdata[i*Gran +: Gran];
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sram_1p_bwe_init.sv
// Single-port synchronous SRAM model with per-lane byte write enables and a
// self-clearing initialisation sequence after reset.
//   CLK, RST  : clock, synchronous active-high reset
//   CEB, WEB  : chip enable / write enable, active low (WEB=1 reads)
//   BWEB      : per-lane write enable, active low, bit i covers D[i*Gran +: Gran]
//   A, D      : word address, write data
//   Q         : registered read data, holds when not reading
//   INIT_DONE : high once every word has been cleared to zero
module sram_1p_bwe_init
  import sram_pkg::*;
#(
  parameter int Bits       = 64,
  parameter int Word_Depth = 128,
  parameter int Add_Width  = 7,
  parameter int Gran       = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CEB,
  input  logic                         WEB,
  input  logic [lanes(Bits,Gran)-1:0]  BWEB,
  input  logic [Add_Width-1:0]         A,
  input  logic [Bits-1:0]              D,
  output logic [Bits-1:0]              Q,
  output logic                         INIT_DONE
);

  localparam int                   Lanes    = lanes(Bits, Gran);
  localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);

  state_e               state_q, state_d;
  logic [Add_Width-1:0] cnt_q, cnt_d;
  logic                 init_done_q, init_done_d;

  logic                 arr_we, arr_re;
  logic [Lanes-1:0]     arr_wmask;
  logic [Add_Width-1:0] arr_addr;
  logic [Bits-1:0]      arr_wdata;

  // Clear sequencer owns the array port in INIT; user pins are ignored there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_wmask = '0;
    arr_addr  = A;
    arr_wdata = D;
    case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_wmask = '1;
        arr_addr  = cnt_q;
        arr_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (!CEB) begin
          arr_we    = !WEB;
          arr_re    = WEB;
          arr_wmask = ~BWEB;
        end
      end
      default: state_d = INIT;
    endcase
    // Reset wins over everything, including the clearing write of this edge.
    if (RST) begin
      state_d = INIT;
      cnt_d   = '0;
      arr_we  = 1'b0;
      arr_re  = 1'b0;
    end
    init_done_d = (state_d == READY);
  end

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    init_done_q <= init_done_d;
  end

  sram_bwe_array #(
    .Bits      (Bits),
    .Word_Depth(Word_Depth),
    .Add_Width (Add_Width),
    .Gran      (Gran)
  ) u_array (
    .clk  (CLK),
    .rst  (RST),
    .we   (arr_we),
    .re   (arr_re),
    .wmask(arr_wmask),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .q    (Q)
  );

  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_sram_1p_bwe_init.sv
// Scoreboard bench: dut_a is a 128-word array, dut_b a 100-word array on a
// 7-bit address (for out-of-range coverage). Stimulus pushes the expected Q
// into a per-DUT queue; monitors pop and compare on the falling edge.
module tb_sram_1p_bwe_init;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_a, ceb_a, web_a, done_a;
  logic [7:0]  bweb_a;
  logic [6:0]  a_a;
  logic [63:0] d_a, q_a;
  logic        rst_b, ceb_b, web_b, done_b;
  logic [7:0]  bweb_b;
  logic [6:0]  a_b;
  logic [63:0] d_b, q_b;

  sram_1p_bwe_init #(.Bits(64), .Word_Depth(128), .Add_Width(7), .Gran(8)) dut_a (
    .CLK(CLK), .RST(rst_a), .CEB(ceb_a), .WEB(web_a), .BWEB(bweb_a),
    .A(a_a), .D(d_a), .Q(q_a), .INIT_DONE(done_a));

  sram_1p_bwe_init #(.Bits(64), .Word_Depth(100), .Add_Width(7), .Gran(8)) dut_b (
    .CLK(CLK), .RST(rst_b), .CEB(ceb_b), .WEB(web_b), .BWEB(bweb_b),
    .A(a_b), .D(d_b), .Q(q_b), .INIT_DONE(done_b));

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) if (exp_a.size() > 0) check("q_a", q_a, exp_a.pop_front());
  always @(negedge CLK) if (exp_b.size() > 0) check("q_b", q_b, exp_b.pop_front());

  // One clock of traffic on the selected DUT (other DUT idles). When chk is
  // set, exp is the Q value required after this edge.
  task automatic cyc(input bit sel, input logic ceb, input logic web, input logic [7:0] bweb,
                     input logic [6:0] a, input logic [63:0] d, input bit chk,
                     input logic [63:0] exp);
    if (!sel) begin
      ceb_a = ceb; web_a = web; bweb_a = bweb; a_a = a; d_a = d; ceb_b = 1'b1;
    end else begin
      ceb_b = ceb; web_b = web; bweb_b = bweb; a_b = a; d_b = d; ceb_a = 1'b1;
    end
    @(posedge CLK); #1;
    if (chk) begin
      if (!sel) exp_a.push_back(exp);
      else      exp_b.push_back(exp);
    end
  endtask

  task automatic rd(input bit sel, input logic [6:0] a, input logic [63:0] exp);
    cyc(sel, 1'b0, 1'b1, 8'hFF, a, 64'h0, 1'b1, exp);
  endtask

  localparam logic [63:0] BL = 64'h11223344_FFFFFFFF;

  initial begin
    int na, nb;
    logic early;
    rst_a = 1; rst_b = 1;
    ceb_a = 1; web_a = 1; bweb_a = 8'hFF; a_a = '0; d_a = '0;
    ceb_b = 1; web_b = 1; bweb_b = 8'hFF; a_b = '0; d_b = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_q_a", q_a, 64'h0);
    check("rst_done_a", 64'(done_a), 64'h0);
    check("rst_q_b", q_b, 64'h0);
    check("rst_done_b", 64'(done_b), 64'h0);

    // Release reset with write traffic that INIT must ignore.
    ceb_a = 0; web_a = 0; bweb_a = 8'h00; a_a = 7'd20; d_a = '1;
    ceb_b = 0; web_b = 0; bweb_b = 8'h00; a_b = 7'd20; d_b = '1;
    rst_a = 0; rst_b = 0;
    na = 0; nb = 0;
    for (int n = 1; n <= 200 && (na == 0 || nb == 0); n++) begin
      @(posedge CLK); #1;
      if (done_a && na == 0) begin na = n; ceb_a = 1; end
      if (done_b && nb == 0) begin nb = n; ceb_b = 1; end
    end
    check("init_edges_a", 64'(na), 64'd128);
    check("init_edges_b", 64'(nb), 64'd100);
    check("init_q_a", q_a, 64'h0);

    rd(0, 7'd0, 64'h0);
    rd(0, 7'd64, 64'h0);
    rd(0, 7'd127, 64'h0);
    rd(0, 7'd20, 64'h0);

    // Byte-lane merge.
    cyc(0, 0, 0, 8'h00, 7'd5, 64'h11223344_55667788, 0, 0);
    cyc(0, 0, 0, 8'hF0, 7'd5, '1, 0, 0);
    rd(0, 7'd5, BL);

    // Q holds across idle cycles, writes and an all-masked write.
    cyc(0, 1, 1, 8'hFF, 7'd0, 64'h0, 1, BL);
    cyc(0, 1, 1, 8'hFF, 7'd0, 64'h0, 1, BL);
    cyc(0, 1, 1, 8'hFF, 7'd0, 64'h0, 1, BL);
    cyc(0, 0, 0, 8'h00, 7'd6, 64'h01020304_05060708, 1, BL);
    cyc(0, 0, 0, 8'hFF, 7'd5, 64'h0, 1, BL);
    rd(0, 7'd5, BL);

    // Read directly after write.
    cyc(0, 0, 0, 8'h00, 7'd9, 64'hA5A5A5A5_A5A5A5A5, 1, BL);
    rd(0, 7'd9, 64'hA5A5A5A5_A5A5A5A5);
    rd(0, 7'd6, 64'h01020304_05060708);

    // Reset, traffic during INIT, reset again at cnt=40.
    repeat (2) @(posedge CLK);
    #1;
    rst_a = 1; ceb_a = 0; web_a = 0; bweb_a = 8'h00; a_a = 7'd100; d_a = '1;
    @(posedge CLK); #1;
    check("rst2_q_a", q_a, 64'h0);
    check("rst2_done_a", 64'(done_a), 64'h0);
    rst_a = 0;
    early = 0;
    for (int n = 0; n < 40; n++) begin
      a_a = 7'(n + 3);
      @(posedge CLK); #1;
      if (done_a) early = 1;
    end
    rst_a = 1;
    @(posedge CLK); #1;
    if (done_a) early = 1;
    rst_a = 0; a_a = 7'd100;
    na = 0;
    for (int n = 1; n <= 200 && na == 0; n++) begin
      @(posedge CLK); #1;
      if (done_a) begin na = n; ceb_a = 1; end
      else if (q_a !== 64'h0) early = 1;
    end
    check("reinit_edges_a", 64'(na), 64'd128);
    check("reinit_low_q0", 64'(early), 64'h0);
    for (int i = 0; i < 128; i++) rd(0, 7'(i), 64'h0);

    // Out-of-range on the 100-word instance.
    cyc(1, 0, 0, 8'h00, 7'd20, 64'hDEADBEEF_01234567, 0, 0);
    cyc(1, 0, 0, 8'h00, 7'd120, '1, 0, 0);
    rd(1, 7'd20, 64'hDEADBEEF_01234567);
    rd(1, 7'd120, 64'h0);
    rd(1, 7'd20, 64'hDEADBEEF_01234567);
    cyc(1, 0, 0, 8'h00, 7'd99, 64'hCAFEF00D_87654321, 0, 0);
    rd(1, 7'd99, 64'hCAFEF00D_87654321);
    rd(1, 7'd0, 64'h0);

    repeat (2) @(posedge CLK);
    #1;
    check("drain_a", 64'(exp_a.size()), 64'h0);
    check("drain_b", 64'(exp_b.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
